// File: rtl/flappy_game_engine.sv
// Flappy game-state engine: FSM, plane physics, three scrolling tubes, collision and score.
// Optional macro GAME_AUTORESTART_EN: DEAD returns to IDLE by itself after 120 frame ticks.
module flappy_game_engine #(
    parameter int         PLANE_X      = 180,
    parameter int         PLANE_HALF   = 15,
    parameter int         TUBE_HALF_W  = 30,
    parameter int         GAP_HALF     = 35,
    parameter int         SCREEN_H     = 480,
    parameter int         GRAVITY      = 1,
    parameter int         FLAP_VEL     = 8,
    parameter int         MAX_FALL     = 10,
    parameter int         SCROLL       = 2,
    parameter int         TUBE_SPACING = 220,
    parameter int         GAP_MIN      = 100,
    parameter logic [7:0] GAP_MASK     = 8'hFF,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       start,
    output logic [9:0] plane_y_pos,
    output logic [9:0] tube1_x_pos,
    output logic [9:0] tube2_x_pos,
    output logic [9:0] tube3_x_pos,
    output logic [9:0] tube1_y_pos,
    output logic [9:0] tube2_y_pos,
    output logic [9:0] tube3_y_pos,
    output logic       game_end,
    output logic [7:0] score
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DEAD} state_t;

    localparam logic signed [11:0] PX   = 12'(PLANE_X);
    localparam logic signed [11:0] PH   = 12'(PLANE_HALF);
    localparam logic signed [11:0] THW  = 12'(TUBE_HALF_W);
    localparam logic signed [11:0] GH   = 12'(GAP_HALF);
    localparam logic signed [11:0] SH1  = 12'(SCREEN_H - 1);
    localparam logic signed [11:0] SCR  = 12'(SCROLL);
    localparam logic signed [11:0] WRAP = 12'(3 * TUBE_SPACING);
    localparam logic signed [7:0]  GRAV  = 8'(GRAVITY);
    localparam logic signed [7:0]  FLAPV = 8'(FLAP_VEL);
    localparam logic signed [7:0]  MAXF  = 8'(MAX_FALL);
    localparam logic [9:0] GAP_RST = 10'(GAP_MIN) + {2'b00, LFSR_SEED & GAP_MASK};

    state_t           state_q, state_d;
    logic [5:0]       btn_q, btn_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [9:0]       y_q, y_d;
    logic [5:0]       vel_q, vel_d;
    logic [2:0][9:0]  tube_x_q, tube_x_d;
    logic [2:0][9:0]  tube_y_q, tube_y_d;
    logic [7:0]       score_q, score_d;
    logic             game_end_q, game_end_d;
    logic             pend_q, pend_d;

    logic             flap_edge, start_edge, go_idle, hit;
    logic [9:0]       gap_new;
    logic signed [7:0]  vs, vg, v;
    logic signed [11:0] ny, xs, nx, dx, adx, gs;
    logic [1:0]       crossings;
    logic [8:0]       score_sum;

`ifdef GAME_AUTORESTART_EN
    logic [6:0] dead_cnt_q, dead_cnt_d;
`endif

    // btn = {start prev, start sync, start meta, flap prev, flap sync, flap meta}
    assign flap_edge  = btn_q[1] & ~btn_q[2];
    assign start_edge = btn_q[4] & ~btn_q[5];
    assign gap_new    = 10'(GAP_MIN) + {2'b00, lfsr_q & GAP_MASK};

    always_comb begin
        btn_d      = {btn_q[4:3], start, btn_q[1:0], flap};
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d    = state_q;
        y_d        = y_q;
        vel_d      = vel_q;
        tube_x_d   = tube_x_q;
        tube_y_d   = tube_y_q;
        score_d    = score_q;
        pend_d     = pend_q;
        go_idle    = 1'b0;
        hit        = 1'b0;
        crossings  = 2'd0;
        vs         = {{2{vel_q[5]}}, vel_q};
        vg         = vs + GRAV;
        v          = 8'sd0;
        ny         = 12'sd0;
        xs         = 12'sd0;
        nx         = 12'sd0;
        dx         = 12'sd0;
        adx        = 12'sd0;
        gs         = 12'sd0;
        score_sum  = 9'd0;
`ifdef GAME_AUTORESTART_EN
        dead_cnt_d = dead_cnt_q;
`endif
        case (state_q)
            S_IDLE: if (start_edge) state_d = S_PLAY;
            S_PLAY: begin
                if (flap_edge) pend_d = 1'b1;
                if (frame_tick) begin
                    // An edge arriving with the tick is kept for the following tick.
                    pend_d = flap_edge;
                    v  = pend_q ? -FLAPV : ((vg > MAXF) ? MAXF : vg);
                    ny = $signed({2'b00, y_q}) + {{4{v[7]}}, v};
                    if (ny < PH) begin
                        ny = PH;
                        v  = 8'sd0;
                    end
                    hit = (ny + PH >= SH1);
                    for (int i = 0; i < 3; i++) begin
                        xs = $signed({2'b00, tube_x_q[i]});
                        nx = xs - SCR;
                        if (xs < SCR) begin
                            nx          = nx + WRAP;
                            tube_y_d[i] = gap_new;
                        end
                        if (xs >= PX && nx < PX) crossings = crossings + 2'd1;
                        gs  = $signed({2'b00, tube_y_d[i]});
                        dx  = PX - nx;
                        adx = dx[11] ? -dx : dx;
                        if (adx <= PH + THW && (ny - PH <= gs - GH || ny + PH >= gs + GH))
                            hit = 1'b1;
                        tube_x_d[i] = nx[9:0];
                    end
                    score_sum = {1'b0, score_q} + {7'd0, crossings};
                    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
                    y_d       = ny[9:0];
                    vel_d     = v[5:0];
                    if (hit) state_d = S_DEAD;
                end
            end
            S_DEAD: begin
                go_idle = start_edge;
`ifdef GAME_AUTORESTART_EN
                if (frame_tick) begin
                    if (dead_cnt_q == 7'd119) go_idle = 1'b1;
                    else dead_cnt_d = dead_cnt_q + 7'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
`ifdef GAME_AUTORESTART_EN
        if (state_q != S_DEAD) dead_cnt_d = 7'd0;
`endif
        if (go_idle) begin
            state_d  = S_IDLE;
            y_d      = 10'd240;
            vel_d    = 6'd0;
            score_d  = 8'd0;
            pend_d   = 1'b0;
            tube_x_d = {10'd940, 10'd720, 10'd500};
            tube_y_d = {gap_new, gap_new, gap_new};
        end
        game_end_d = (state_d == S_DEAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            btn_q      <= 6'd0;
            lfsr_q     <= LFSR_SEED;
            y_q        <= 10'd240;
            vel_q      <= 6'd0;
            tube_x_q   <= {10'd940, 10'd720, 10'd500};
            tube_y_q   <= {GAP_RST, GAP_RST, GAP_RST};
            score_q    <= 8'd0;
            game_end_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            lfsr_q     <= lfsr_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            tube_x_q   <= tube_x_d;
            tube_y_q   <= tube_y_d;
            score_q    <= score_d;
            game_end_q <= game_end_d;
            pend_q     <= pend_d;
        end
    end

`ifdef GAME_AUTORESTART_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dead_cnt_q <= 7'd0;
        else     dead_cnt_q <= dead_cnt_d;
    end
`endif

    assign plane_y_pos = y_q;
    assign tube1_x_pos = tube_x_q[0];
    assign tube2_x_pos = tube_x_q[1];
    assign tube3_x_pos = tube_x_q[2];
    assign tube1_y_pos = tube_y_q[0];
    assign tube2_y_pos = tube_y_q[1];
    assign tube3_y_pos = tube_y_q[2];
    assign game_end    = game_end_q;
    assign score       = score_q;
endmodule
